param_updn_cntr: RTL and testbench

Parametrised up/down counter with a programmable count range, selectable wrap or saturate overflow, synchronous parallel load, and an automatic ping-pong (bounce) mode. It runs on the divided slow_clk so that count activity is visible on board LEDs and 7-segment displays. It replaces the fixed 3-bit up/down counter in the FPGA implementation set, and its outputs drive the display and LED logic directly.

---
 rtl/cntr_pkg.sv | 10 +
 rtl/cntr_next_val.sv | 95 +++++++++
 rtl/param_updn_cntr.sv | 105 ++++++++++
 tb/tb_param_updn_cntr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// Shared mode encodings for the parametrised up/down counter.
package cntr_pkg;

  typedef logic [1:0] cntr_mode_t;

  localparam cntr_mode_t MODE_DIR      = 2'b00;
  localparam cntr_mode_t MODE_PINGPONG = 2'b01;
  localparam cntr_mode_t MODE_HOLD     = 2'b10;

endpackage

// File: rtl/cntr_next_val.sv
// Combinational next count/direction and event flags for one enabled step.
// Mode 11 and MODE_HOLD both hold; an out-of-range count snaps to MIN_VAL with wrap.
module cntr_next_val
  import cntr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 9,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_cnt,
  output logic             next_dir,
  output logic             wrap_n,
  output logic             turn_n
);

  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;
  logic           out_of_range;
  logic           below_max;
  logic           above_min;

  assign cnt_x = {1'b0, cnt};
  assign inc_x = cnt_x + 1'b1;
  assign dec_x = cnt_x - 1'b1;
  // inc_x <= MIN_X is cnt < MIN_VAL without a constant compare against zero
  assign out_of_range = (inc_x <= MIN_X) || (cnt_x > MAX_X);
  assign below_max    = cnt_x < MAX_X;
  assign above_min    = cnt_x > MIN_X;

  always_comb begin
    next_cnt = cnt;
    next_dir = dir;
    wrap_n   = 1'b0;
    turn_n   = 1'b0;
    case (cntr_mode_t'(mode))
      MODE_DIR: begin
        next_dir = up_dn;
        if (out_of_range) begin
          next_cnt = MIN_X[WIDTH-1:0];
          wrap_n   = 1'b1;
        end else if (up_dn) begin
          if (below_max) begin
            next_cnt = inc_x[WIDTH-1:0];
          end else begin
            wrap_n = 1'b1;
            if (SATURATE == 0) next_cnt = MIN_X[WIDTH-1:0];
          end
        end else begin
          if (above_min) begin
            next_cnt = dec_x[WIDTH-1:0];
          end else begin
            wrap_n = 1'b1;
            if (SATURATE == 0) next_cnt = MAX_X[WIDTH-1:0];
          end
        end
      end
      MODE_PINGPONG: begin
        if (out_of_range) begin
          next_cnt = MIN_X[WIDTH-1:0];
          wrap_n   = 1'b1;
        end else if (dir) begin
          if (below_max) begin
            next_cnt = inc_x[WIDTH-1:0];
          end else begin
            next_cnt = dec_x[WIDTH-1:0];
            next_dir = 1'b0;
            turn_n   = 1'b1;
          end
        end else begin
          if (above_min) begin
            next_cnt = dec_x[WIDTH-1:0];
          end else begin
            next_cnt = inc_x[WIDTH-1:0];
            next_dir = 1'b1;
            turn_n   = 1'b1;
          end
        end
      end
      default: begin
        next_cnt = cnt;
        next_dir = dir;
      end
    endcase
  end

endmodule

// File: rtl/param_updn_cntr.sv
// Up/down counter with programmable range, wrap/saturate policy, load and ping-pong.
// All outputs registered; priority rst > load > enabled step > hold.
module param_updn_cntr
  import cntr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 9,
  parameter int SATURATE = 0
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             turn
);

  if (WIDTH < 2 || WIDTH > 16 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_params
    $error("param_updn_cntr: illegal WIDTH/MIN_VAL/MAX_VAL combination");
  end

  localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH-1:0] next_cnt;
  logic             next_dir;
  logic             wrap_n;
  logic             turn_n;
  logic [WIDTH:0]   lv_x;
  logic [WIDTH:0]   lv_inc;
  logic [WIDTH-1:0] lv_clamped;
  logic [WIDTH-1:0] cnt_d;
  logic             dir_d;
  logic             wrap_d;
  logic             turn_d;

  cntr_next_val #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .SATURATE(SATURATE)
  ) u_next (
    .cnt     (cnt),
    .dir     (dir),
    .mode    (mode),
    .up_dn   (up_dn),
    .next_cnt(next_cnt),
    .next_dir(next_dir),
    .wrap_n  (wrap_n),
    .turn_n  (turn_n)
  );

  assign lv_x   = {1'b0, load_val};
  assign lv_inc = lv_x + 1'b1;

  always_comb begin
    lv_clamped = load_val;
    if (lv_inc <= MIN_X)     lv_clamped = MIN_X[WIDTH-1:0];
    else if (lv_x > MAX_X)   lv_clamped = MAX_X[WIDTH-1:0];
  end

  always_comb begin
    cnt_d  = cnt;
    dir_d  = dir;
    wrap_d = 1'b0;
    turn_d = 1'b0;
    if (load) begin
      cnt_d = lv_clamped;
    end else if (en) begin
      cnt_d  = next_cnt;
      dir_d  = next_dir;
      wrap_d = wrap_n;
      turn_d = turn_n;
    end
  end

  // Bound flags come from cnt_d so they line up with the registered cnt
  always_ff @(posedge slow_clk) begin
    if (rst) begin
      cnt    <= MIN_X[WIDTH-1:0];
      dir    <= 1'b1;
      at_max <= 1'b0;
      at_min <= 1'b1;
      wrap   <= 1'b0;
      turn   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      dir    <= dir_d;
      at_max <= ({1'b0, cnt_d} == MAX_X);
      at_min <= ({1'b0, cnt_d} == MIN_X);
      wrap   <= wrap_d;
      turn   <= turn_d;
    end
  end

endmodule

// File: tb/tb_param_updn_cntr.sv
// Directed bench: wrap instance (0..9), saturate instance (0..9), narrow-range instance (2..7).
module tb_param_updn_cntr;

  logic       slow_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [2:0] load_val3;

  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic dir0, at_max0, at_min0, wrap0, turn0;
  logic dir1, at_max1, at_min1, wrap1, turn1;
  logic dir2, at_max2, at_min2, wrap2, turn2;

  int total = 0;
  int bad = 0;

  assign load_val3 = load_val[2:0];

  always #5 slow_clk = ~slow_clk;

  param_updn_cntr #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .SATURATE(0)) u_wrap (
    .slow_clk(slow_clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .cnt(cnt0), .dir(dir0),
    .at_max(at_max0), .at_min(at_min0), .wrap(wrap0), .turn(turn0));

  param_updn_cntr #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .SATURATE(1)) u_sat (
    .slow_clk(slow_clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .cnt(cnt1), .dir(dir1),
    .at_max(at_max1), .at_min(at_min1), .wrap(wrap1), .turn(turn1));

  param_updn_cntr #(.WIDTH(3), .MIN_VAL(2), .MAX_VAL(7), .SATURATE(0)) u_rng (
    .slow_clk(slow_clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val3), .cnt(cnt2), .dir(dir2),
    .at_max(at_max2), .at_min(at_min2), .wrap(wrap2), .turn(turn2));

  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; up_dn = 1'b1;
    step(); step();
    total++;
    if ({cnt0, dir0, at_min0, at_max0, wrap0, turn0} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_wrap: cnt=%0d dir=%b min=%b max=%b wrap=%b turn=%b, want cnt=0 dir=1 min=1 max=0 wrap=0 turn=0",
               cnt0, dir0, at_min0, at_max0, wrap0, turn0);
    end
    total++;
    if ({cnt2, dir2, at_min2, at_max2} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_rng: cnt=%0d dir=%b min=%b max=%b, want cnt=2 dir=1 min=1 max=0",
               cnt2, dir2, at_min2, at_max2);
    end
  endtask

  task automatic test_dir_up();
    int exp_cnt;
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; mode = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_cnt = (i + 1) % 10;
      total++;
      if ({cnt0, wrap0, at_max0, at_min0} !== {4'(exp_cnt), (i == 9), (exp_cnt == 9), (exp_cnt == 0)}) begin
        bad++;
        $display("FAIL dir_up[%0d]: cnt=%0d wrap=%b max=%b min=%b, want cnt=%0d wrap=%b max=%b min=%b",
                 i, cnt0, wrap0, at_max0, at_min0, exp_cnt, (i == 9), (exp_cnt == 9), (exp_cnt == 0));
      end
    end
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_sat [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0] exp_wrp [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0; up_dn = 1'b0; en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({cnt1, wrap1, at_min1} !== {exp_sat[i], (i >= 2), (i >= 1)}) begin
        bad++;
        $display("FAIL sat_down[%0d]: cnt=%0d wrap=%b min=%b, want cnt=%0d wrap=%b min=%b",
                 i, cnt1, wrap1, at_min1, exp_sat[i], (i >= 2), (i >= 1));
      end
      total++;
      if ({cnt0, wrap0} !== {exp_wrp[i], (i == 2)}) begin
        bad++;
        $display("FAIL wrap_down[%0d]: cnt=%0d wrap=%b, want cnt=%0d wrap=%b",
                 i, cnt0, wrap0, exp_wrp[i], (i == 2));
      end
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] exp_c [6] = '{4'd8, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    logic       exp_d [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    up_dn = 1'b1; en = 1'b1; mode = 2'b00;
    step();
    load = 1'b1; load_val = 4'd7;
    step();
    total++;
    if ({cnt0, dir0} !== {4'd7, 1'b1}) begin
      bad++;
      $display("FAIL pp_load: cnt=%0d dir=%b, want cnt=7 dir=1", cnt0, dir0);
    end
    load = 1'b0; mode = 2'b01; up_dn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({cnt0, dir0, turn0, wrap0, at_max0} !== {exp_c[i], exp_d[i], (i == 2), 1'b0, (i == 1)}) begin
        bad++;
        $display("FAIL pingpong[%0d]: cnt=%0d dir=%b turn=%b wrap=%b max=%b, want cnt=%0d dir=%b turn=%b wrap=0 max=%b",
                 i, cnt0, dir0, turn0, wrap0, at_max0, exp_c[i], exp_d[i], (i == 2), (i == 1));
      end
    end
  endtask

  task automatic test_load_clamp();
    mode = 2'b00; en = 1'b1; up_dn = 1'b1;
    load = 1'b1; load_val = 4'd14;
    step();
    total++;
    if ({cnt0, at_max0, dir0} !== {4'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL load_clamp: cnt=%0d max=%b dir=%b, want cnt=9 max=1 dir=0", cnt0, at_max0, dir0);
    end
    total++;
    if (cnt2 !== 3'd6) begin
      bad++;
      $display("FAIL load_rng: cnt=%0d, want 6", cnt2);
    end
    rst = 1'b1; load_val = 4'd3;
    step();
    total++;
    if ({cnt0, dir0, at_min0, at_max0} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_over_load: cnt=%0d dir=%b min=%b max=%b, want cnt=0 dir=1 min=1 max=0",
               cnt0, dir0, at_min0, at_max0);
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0; mode = 2'b00; up_dn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en   = (i >= 3);
      mode = (i == 6) ? 2'b11 : (i >= 3 ? 2'b10 : 2'b00);
      step();
      total++;
      if ({cnt0, dir0, wrap0, turn0} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold[%0d]: cnt=%0d dir=%b wrap=%b turn=%b, want cnt=5 dir=1 wrap=0 turn=0",
                 i, cnt0, dir0, wrap0, turn0);
      end
    end
  endtask

  task automatic test_param_wrap();
    int exp_cnt;
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; up_dn = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_cnt = (i == 5) ? 2 : i + 3;
      total++;
      if ({cnt2, wrap2, at_max2} !== {3'(exp_cnt), (i == 5), (exp_cnt == 7)} || cnt2 < 3'd2) begin
        bad++;
        $display("FAIL rng_up[%0d]: cnt=%0d wrap=%b max=%b, want cnt=%0d wrap=%b max=%b",
                 i, cnt2, wrap2, at_max2, exp_cnt, (i == 5), (exp_cnt == 7));
      end
    end
    up_dn = 1'b0;
    step();
    total++;
    if ({cnt2, wrap2, at_max2} !== {3'd7, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL rng_down: cnt=%0d wrap=%b max=%b, want cnt=7 wrap=1 max=1", cnt2, wrap2, at_max2);
    end
    load = 1'b1; load_val = 4'd0;
    step();
    total++;
    if ({cnt2, at_min2} !== {3'd2, 1'b1}) begin
      bad++;
      $display("FAIL rng_clamp_low: cnt=%0d min=%b, want cnt=2 min=1", cnt2, at_min2);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dir_up();
    test_sat_down();
    test_pingpong();
    test_load_clamp();
    test_hold();
    test_param_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
